serial_add_sequencer: RTL and testbench

//  Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in,

---
 rtl/serial_add_sequencer_pkg.sv | 20 ++
 rtl/serial_add_sequencer_full_adder.sv | 13 +
 rtl/serial_add_sequencer.sv | 132 +++++++++++++
 tb/tb_serial_add_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the iteration counter width helper.
package serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A single-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/serial_add_sequencer_full_adder.sv
// Single-bit full adder cell shared by the serial add sequencer.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_in_i,
  output logic sum_o,
  output logic carry_out_o
);

  assign sum_o       = a_i ^ b_i ^ carry_in_i;
  assign carry_out_o = (a_i & b_i) | (carry_in_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: walks one full_adder LSB-first over WIDTH cycles
// and publishes {carry, sum} with a one-cycle done pulse.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             carry_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_shift_s;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_sum_s;
  logic             fa_cout_s;

  full_adder u_full_adder (
    .a_i         (a_q[0]),
    .b_i         (b_q[0]),
    .carry_in_i  (carry_q),
    .sum_o       (fa_sum_s),
    .carry_out_o (fa_cout_s)
  );

  // Result shift register fills from the MSB so the LSB lands in bit 0 last.
  always_comb begin
    res_shift_s            = res_q >> 1'b1;
    res_shift_s[WIDTH-1]   = fa_sum_s;
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          a_d     = operand_a_i;
          b_d     = operand_b_i;
          carry_d = carry_in_i;
          res_d   = {WIDTH{1'b0}};
          count_d = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1'b1;
        b_d     = b_q >> 1'b1;
        res_d   = res_shift_s;
        carry_d = fa_cout_s;
        if (count_q == LAST_COUNT) begin
          count_d = {CW{1'b0}};
          sum_d   = res_shift_s;
          cout_d  = fa_cout_s;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= {CW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer at WIDTH=8, 2 and 1.
module tb_serial_add_sequencer;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q1[$];

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = 2'd0, b2 = 2'd0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .operand_a_i(a8), .operand_b_i(b8),
    .carry_in_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .carry_out_o(cout8));

  serial_add_sequencer #(.WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .operand_a_i(a2), .operand_b_i(b2),
    .carry_in_i(cin2), .busy_o(busy2), .done_o(done2), .sum_o(sum2), .carry_out_o(cout2));

  serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .operand_a_i(a1), .operand_b_i(b1),
    .carry_in_i(cin1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .carry_out_o(cout1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitors: pop on every done pulse, flag spurious or overdue completions.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst) begin
      if (done8) begin
        if (q8.size() == 0) begin
          chk("w8_spurious_done", {31'd0, done8}, 32'd0);
        end else begin
          e = q8.pop_front();
          chk("w8_sum", {24'd0, sum8}, {24'd0, e.sum});
          chk("w8_cout", {31'd0, cout8}, {31'd0, e.cout});
          chk("w8_done_cycle", cyc, e.due);
        end
      end else if (q8.size() != 0 && cyc > q8[0].due) begin
        e = q8.pop_front();
        chk("w8_missing_done", {31'd0, done8}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst) begin
      if (done2) begin
        if (q2.size() == 0) begin
          chk("w2_spurious_done", {31'd0, done2}, 32'd0);
        end else begin
          e = q2.pop_front();
          chk("w2_result", {29'd0, cout2, sum2}, {29'd0, e.cout, e.sum[1:0]});
          chk("w2_done_cycle", cyc, e.due);
        end
      end else if (q2.size() != 0 && cyc > q2[0].due) begin
        e = q2.pop_front();
        chk("w2_missing_done", {31'd0, done2}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst) begin
      if (done1) begin
        if (q1.size() == 0) begin
          chk("w1_spurious_done", {31'd0, done1}, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("w1_result", {30'd0, cout1, sum1}, {30'd0, e.cout, e.sum[0]});
          chk("w1_done_cycle", cyc, e.due);
        end
      end else if (q1.size() != 0 && cyc > q1[0].due) begin
        e = q1.pop_front();
        chk("w1_missing_done", {31'd0, done1}, 32'd1);
      end
    end
  end

  // Accept edge returns acc = cyc after that edge; done is due WIDTH edges later.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input bit push, input logic [7:0] exp_sum, input logic exp_cout,
                        output int acc);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) q8.push_back('{sum: exp_sum, cout: exp_cout, due: acc + 8});
    start8 = 1'b0;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (n < 40 && ((which == 8 && q8.size() != 0) || (which == 2 && q2.size() != 0) ||
                      (which == 1 && q1.size() != 0))) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin : stim
    int acc;
    int s;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int acc;
    int s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    chk("reset_done", {31'd0, done8}, 32'd0);
    chk("reset_sum", {24'd0, sum8}, 32'd0);
    chk("reset_cout", {31'd0, cout8}, 32'd0);
    rst = 1'b0;

    // 1: basic add with busy/done timing
    issue8(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, acc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t1_busy", {31'd0, busy8}, {31'd0, (cyc - acc) < 8});
    end
    drain(8);

    // 2: overflow cases
    issue8(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, acc);
    drain(8);
    issue8(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, acc);
    drain(8);

    // 3: start mid-add is ignored
    issue8(8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, acc);
    while (cyc < acc + 4) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain(8);
    repeat (12) @(negedge clk);
    chk("t3_sum_kept", {24'd0, sum8}, 32'h46);

    // 4: start held through DONE -> back-to-back add
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    q8.push_back('{sum: 8'h10, cout: 1'b0, due: acc + 8});
    q8.push_back('{sum: 8'h05, cout: 1'b0, due: acc + 17});
    a8 = 8'h02; b8 = 8'h03;
    while (cyc < acc + 9) @(negedge clk);
    start8 = 1'b0;
    while (cyc < acc + 17) begin
      chk("t4_sum_hold", {24'd0, sum8}, 32'h10);
      @(negedge clk);
    end
    drain(8);

    // 5: reset mid-add aborts
    issue8(8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, acc);
    while (cyc < acc + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy8}, 32'd0);
    chk("t5_done", {31'd0, done8}, 32'd0);
    chk("t5_sum", {24'd0, sum8}, 32'd0);
    chk("t5_cout", {31'd0, cout8}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue8(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, acc);
    drain(8);

    // 6: WIDTH=2 exhaustive
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          start2 = 1'b1; a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c);
          @(posedge clk);
          #1;
          s = a + b + c;
          q2.push_back('{sum: 8'(s % 4), cout: 1'(s / 4), due: cyc + 2});
          start2 = 1'b0;
          drain(2);
        end
      end
    end

    // WIDTH=1 smoke: 1+1
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk);
    #1;
    q1.push_back('{sum: 8'h00, cout: 1'b1, due: cyc + 1});
    start1 = 1'b0;
    drain(1);

    repeat (4) @(negedge clk);
    chk("final_q8_empty", q8.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
